// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF controller: one shared update datapath sweeps N virtual
// neurons round-robin on each tick and publishes the sweep's spike vector.
module lif_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8,
  parameter int THRESHOLD = 200,
  parameter int REFRACT   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tick,
  input  logic                         cur_we,
  input  logic [$clog2(N_NEURONS)-1:0] cur_addr,
  input  logic [WIDTH-1:0]             cur_data,
  input  logic [$clog2(N_NEURONS)-1:0] rd_addr,
  output logic [WIDTH-1:0]             state_out,
  output logic [N_NEURONS-1:0]         spikes,
  output logic                         done,
  output logic                         busy,
  output logic                         overrun
);

  localparam int AW = $clog2(N_NEURONS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [WIDTH-1:0] TH   = WIDTH'(THRESHOLD);
  localparam logic [2:0]       RF   = 3'(REFRACT);
  localparam logic [AW-1:0]    LAST = AW'(N_NEURONS - 1);

  logic [1:0]           fsm_q, fsm_d;
  logic [AW-1:0]        idx_q;
  logic [WIDTH-1:0]     state_q  [N_NEURONS];
  logic [WIDTH-1:0]     cur_q    [N_NEURONS];
  logic [WIDTH-1:0]     shadow_q [N_NEURONS];
  logic [2:0]           refr_q   [N_NEURONS];
  logic [N_NEURONS-1:0] acc_q, acc_d, spikes_q;
  logic                 done_q, busy_q, overrun_q;
  logic [WIDTH-1:0]     state_out_q, state_out_d;
  logic [WIDTH+3:0]     upd_d;

  // Packs {spike, next refractory count, next membrane state}; spike uses the pre-update state.
  function automatic logic [WIDTH+3:0] lif_update(input logic [WIDTH-1:0] s,
                                                  input logic [WIDTH-1:0] c,
                                                  input logic [2:0]       r);
    logic             spk;
    logic [WIDTH-1:0] c_eff, sat, nxt;
    logic [WIDTH:0]   sum;
    logic [2:0]       r_nxt;
    spk   = (s >= TH);
    c_eff = (r != 3'd0) ? {WIDTH{1'b0}} : c;
    sum   = {1'b0, c_eff} + {2'b00, s[WIDTH-1:1]};
    sat   = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    if (spk) begin
      nxt   = (sat >= TH) ? (sat - TH) : {WIDTH{1'b0}};
      r_nxt = RF;
    end else begin
      nxt   = sat;
      r_nxt = (r != 3'd0) ? (r - 3'd1) : 3'd0;
    end
    return {spk, r_nxt, nxt};
  endfunction

  // Next-state logic: FSM transition, shared update datapath and readout bypass.
  always_comb begin
    upd_d = lif_update(state_q[idx_q], shadow_q[idx_q], refr_q[idx_q]);
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:  if (tick) fsm_d = S_RUN; else fsm_d = S_IDLE;
      S_RUN:   if (idx_q == LAST) fsm_d = S_DONE; else fsm_d = S_RUN;
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
    acc_d        = acc_q;
    acc_d[idx_q] = upd_d[WIDTH+3];
    // Readout sees an update landing on the same edge.
    if ((fsm_q == S_RUN) && (idx_q == rd_addr)) begin
      state_out_d = upd_d[WIDTH-1:0];
    end else begin
      state_out_d = state_q[rd_addr];
    end
  end

  // State registers, neuron memories and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= S_IDLE;
      idx_q       <= {AW{1'b0}};
      acc_q       <= {N_NEURONS{1'b0}};
      spikes_q    <= {N_NEURONS{1'b0}};
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      state_out_q <= {WIDTH{1'b0}};
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i]  <= {WIDTH{1'b0}};
        cur_q[i]    <= {WIDTH{1'b0}};
        shadow_q[i] <= {WIDTH{1'b0}};
        refr_q[i]   <= 3'd0;
      end
    end else begin
      fsm_q       <= fsm_d;
      busy_q      <= (fsm_d != S_IDLE);
      done_q      <= (fsm_d == S_DONE);
      state_out_q <= state_out_d;
      if (tick && (fsm_q != S_IDLE)) overrun_q <= 1'b1;
      if (cur_we) cur_q[cur_addr] <= cur_data;
      case (fsm_q)
        S_IDLE: begin
          if (tick) begin
            // A write on the tick edge must reach the shadow directly.
            for (int i = 0; i < N_NEURONS; i++) begin
              shadow_q[i] <= (cur_we && (cur_addr == AW'(i))) ? cur_data : cur_q[i];
            end
            idx_q <= {AW{1'b0}};
            acc_q <= {N_NEURONS{1'b0}};
          end
        end
        S_RUN: begin
          state_q[idx_q] <= upd_d[WIDTH-1:0];
          refr_q[idx_q]  <= upd_d[WIDTH+2:WIDTH];
          acc_q          <= acc_d;
          if (idx_q == LAST) begin
            spikes_q <= acc_d;
            idx_q    <= {AW{1'b0}};
          end else begin
            idx_q <= idx_q + AW'(1'b1);
          end
        end
        S_DONE:  ;
        default: ;
      endcase
    end
  end

  assign state_out = state_out_q;
  assign spikes    = spikes_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
